fetch_byte_stream: RTL and testbench
====================================

# fetch_byte_stream

Front-end byte supplier for the x86-64 decoder. Reads instruction memory one byte per request at a program counter it owns, absorbs the fixed memory read latency, and buffers the returned bytes. Presents them to the decode stage as an `inst`/`pc` pair with a validity flag. Sits between instruction memory and `fetch_phase`, and is the producing end of that stage's `inst`/`pc`/`stall`/`flush` interface.

## Interface
Parameters:
- `LOAD_LATENCY`, default 1: cycles from `imem_rd` to `imem_data`; must be ≥ 1.
- `RESET_PC`, default 0: fetch address after reset.
- `DEPTH` (localparam): `LOAD_LATENCY+2`, the number of FIFO entries and the credit limit.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `imem_rd` out 1: read request this cycle.
- `imem_addr` out `addr_t`: byte address of the request.
- `imem_data` in `inst_t`: read data, valid exactly `LOAD_LATENCY` cycles after the request.
- `inst` out `inst_t`: current byte for the decoder.
- `pc` out `addr_t`: address of `inst`.
- `byte_valid` out 1: `inst`/`pc` hold a real byte.
  - The top level ORs `~byte_valid` into the decoder's stall input.
- `stall` in 1: back-end stall. The decoder does not consume a byte this cycle.
- `flush` in 1: discard all buffered and in-flight bytes, then redirect.
- `redirect_pc` in `addr_t`: new fetch address, sampled when `flush`=1.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - In-flight tracker: a `LOAD_LATENCY`-deep shift register of {`v`, `pc`}.
  - Output FIFO: `DEPTH` entries of {`inst`, `pc`}.
- Consume: `cons = byte_valid & ~stall & ~flush`. Consume pops the FIFO head.
- Credit: `occ = fifo_count + inflight_count`.
- Request:
  - `imem_rd = ~flush & ((occ - cons) < DEPTH)`. A consume in the same cycle frees a credit.
  - `imem_addr = fetch_pc`.
  - On a request, `fetch_pc <= fetch_pc + 1`, wrapping modulo 2^width(`addr_t`).
- Tracker:
  - Each cycle, the tracker shifts in {`imem_rd`, `imem_addr`}.
  - The entry that reaches the tail marks the current `imem_data` as valid with that pc.
  - A valid tail entry is pushed to the FIFO with `imem_data`.
- FIFO:
  - Head drives `inst`/`pc`.
  - `byte_valid = (fifo_count != 0)`.
  - A push and a pop in the same cycle are both allowed when the FIFO is full.
  - The credit rule makes overflow impossible. Verification asserts that no push occurs while the FIFO is full without a pop.
- Flush (dominates stall):
  - On the `flush` edge: all tracker `v` bits clear, the FIFO empties, and `fetch_pc <= redirect_pc`.
  - Data that returns in the flush cycle is dropped.
  - No request is issued in the flush cycle.
- Stall: the FIFO head holds. Requests continue until `occ` reaches `DEPTH`, then stop.
- No state machine beyond the FIFO and credit; the block always fetches forward.

## Timing
- Reset values:
  - `imem_rd`=0 during reset; `imem_addr`=`RESET_PC`.
  - `inst`=0, `pc`=`RESET_PC`, `byte_valid`=0.
  - FIFO and tracker are empty; `fetch_pc`=`RESET_PC`.
- First request is in the first cycle after `rstn` rises.
- Request to `byte_valid`, without bypass: `LOAD_LATENCY+1` cycles.
- Flush asserted in cycle T:
  - First request at T+1.
  - `byte_valid` at T+2+`LOAD_LATENCY` without bypass, or at T+1+`LOAD_LATENCY` with bypass.
- Throughput is 1 byte/cycle sustained with no stall.
- Reset asserted mid-operation has the same effect as a flush to `RESET_PC`, and also sets `imem_rd`=0.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a valid byte returns, `inst`/`pc`/`byte_valid` are driven directly from `imem_data` and the tracker tail in the same cycle.
  - The byte is pushed only if it is not consumed that cycle.
  - Flush-to-first-byte latency drops by 1.
- Not defined: all output comes from the registered FIFO head, with no combinational path from `imem_data` to the outputs.

## Structure
- `addr_t` and `inst_t` come from the shared common params headers.
- The tracker entry struct `fetch_track_t` {`v`, `pc`} is added to the shared package.
- Sub-module `fetch_byte_fifo`: parameterised depth, push/pop/clear, count output, combinational head.
- The credit logic, tracker and bypass stay in the top module.

## Test plan
Common setup: `LOAD_LATENCY`=1, `RESET_PC`=0, memory model with mem[a]=a+0x10.
- Reset, then free run with no stall → `imem_rd`=1 from cycle 1. `byte_valid` rises at cycle 3 (2 with bypass), with `inst`=0x10, `pc`=0, then 0x11/1, 0x12/2 on consecutive cycles, with no gaps.
- `stall` held for 10 cycles at steady state → `inst`/`pc` frozen. `imem_rd` drops after `occ`=3. On release, bytes continue with no skipped or duplicated pc.
- `flush` with `redirect_pc`=0x40 while 3 bytes are buffered and 1 is in flight → no old byte appears. First valid byte is 0x50/0x40 at T+3 (T+2 with bypass).
- `flush` and `stall` in the same cycle, with data returning that cycle → the flush wins and the returning byte is discarded.
- `RESET_PC`=max `addr_t` − 1 → `pc` sequence max−1, max, 0, 1, with data matching mem.
- Randomised `stall` at 50% for 1000 cycles → the pc sequence is strictly consecutive and the FIFO-overflow assertion never fires.

Source files
------------

// File: rtl/fetch_byte_stream_pkg.sv
// Shared types for the byte-stream fetch front end.
// Address/instruction widths and the in-flight tracker entry.
package fetch_byte_stream_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        logic  v;
        addr_t pc;
    } fetch_track_t;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fetch_entry_t;

    function automatic addr_t pc_inc(addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_byte_stream_fifo.sv
// Small circular FIFO of {inst, pc} with clear and combinational head.
// Push and pop may both occur when full.
module fetch_byte_fifo
    import fetch_byte_stream_pkg::*;
#(
    parameter int    DEPTH  = 3,
    parameter addr_t RST_PC = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;

    function automatic logic [PW-1:0] ptr_nxt(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        if (push_i) wr_d = ptr_nxt(wr_q);
        if (pop_i)  rd_d = ptr_nxt(rd_q);
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{inst: '0, pc: RST_PC};
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_i && !clr_i) mem_q[wr_q] <= push_data_i;
        end
    end

    // Credit accounting upstream must make this unreachable.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rstn)
        !(push_i && full && !pop_i)
    );

endmodule

// File: rtl/fetch_byte_stream.sv
// Byte fetch front end: credit-limited requests, latency tracker, output FIFO.
// Define FETCH_BYPASS_EN to forward returning data straight to an empty output.
module fetch_byte_stream
    import fetch_byte_stream_pkg::*;
#(
    parameter int    LOAD_LATENCY = 1,
    parameter addr_t RESET_PC     = '0
) (
    input  logic  clk,
    input  logic  rstn,
    output logic  imem_rd,
    output addr_t imem_addr,
    input  inst_t imem_data,
    output inst_t inst,
    output addr_t pc,
    output logic  byte_valid,
    input  logic  stall,
    input  logic  flush,
    input  addr_t redirect_pc
);

    localparam int DEPTH = LOAD_LATENCY + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = CW + 1;

    addr_t                           fetch_pc_q, fetch_pc_d;
    fetch_track_t [LOAD_LATENCY-1:0] trk_q, trk_d;
    fetch_track_t                    tail;
    fetch_entry_t                    head;
    fetch_entry_t                    push_data;
    logic [CW-1:0]                   fifo_cnt;
    logic [CW-1:0]                   infl_cnt;
    logic [OW-1:0]                   occ;
    logic [OW-1:0]                   occ_left;
    logic                            fifo_empty;
    logic                            push;
    logic                            pop;
    logic                            cons;

    assign tail = trk_q[LOAD_LATENCY-1];

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            infl_cnt = infl_cnt + CW'(trk_q[i].v);
        end
    end

    assign cons     = byte_valid & ~stall & ~flush;
    assign occ      = OW'(fifo_cnt) + OW'(infl_cnt);
    // A byte consumed this cycle frees its slot for a new request.
    assign occ_left = occ - OW'(cons);

    assign imem_rd   = rstn & ~flush & (occ_left < OW'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign push_data = '{inst: imem_data, pc: tail.pc};
    assign pop       = cons & ~fifo_empty;

`ifdef FETCH_BYPASS_EN
    logic byp;

    assign byp        = fifo_empty & tail.v;
    assign byte_valid = rstn & (~fifo_empty | tail.v);
    assign inst       = byp ? imem_data : head.inst;
    assign pc         = byp ? tail.pc : head.pc;
    assign push       = rstn & tail.v & ~flush & ~(byp & cons);
`else
    assign byte_valid = rstn & ~fifo_empty;
    assign inst       = head.inst;
    assign pc         = head.pc;
    assign push       = rstn & tail.v & ~flush;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_rd) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
        end
    end

    always_comb begin
        trk_d    = '0;
        trk_d[0] = '{v: imem_rd, pc: imem_addr};
        for (int i = 1; i < LOAD_LATENCY; i++) begin
            trk_d[i] = trk_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < LOAD_LATENCY; i++) begin
                trk_d[i].v = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            trk_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            trk_q      <= trk_d;
        end
    end

    fetch_byte_fifo #(
        .DEPTH  (DEPTH),
        .RST_PC (RESET_PC)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_byte_stream.sv
// Self-checking bench for fetch_byte_stream with memory model mem[a]=a+0x10.
// Works with or without FETCH_BYPASS_EN.
module tb_fetch_byte_stream;
    import fetch_byte_stream_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int    DEPTH = 3;
    localparam addr_t WPC   = 64'hFFFF_FFFF_FFFF_FFFE;

    logic  clk = 1'b0;
    logic  rstn, stall, flush;
    addr_t redirect_pc;
    logic  imem_rd, byte_valid;
    addr_t imem_addr, pc;
    inst_t imem_data, inst;

    logic  rd_w, bv_w;
    addr_t addr_w, pc_w;
    inst_t data_w, inst_w;
    logic  zero_b = 1'b0;
    addr_t zero_a = '0;

    int checks = 0;
    int failures = 0;
    int ncons = 0;

    always #5 clk = ~clk;

    fetch_byte_stream #(.LOAD_LATENCY(1), .RESET_PC(64'h0)) dut (
        .clk(clk), .rstn(rstn), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .inst(inst), .pc(pc), .byte_valid(byte_valid),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
    );

    fetch_byte_stream #(.LOAD_LATENCY(1), .RESET_PC(WPC)) dut_w (
        .clk(clk), .rstn(rstn), .imem_rd(rd_w), .imem_addr(addr_w),
        .imem_data(data_w), .inst(inst_w), .pc(pc_w), .byte_valid(bv_w),
        .stall(zero_b), .flush(zero_b), .redirect_pc(zero_a)
    );

    function automatic inst_t mb(addr_t a);
        addr_t t;
        t = a + 64'h10;
        return t[7:0];
    endfunction

    // One-cycle-latency memory; 0xEE marks cycles with no returning data.
    always @(posedge clk) begin
        imem_data <= imem_rd ? mb(imem_addr) : 8'hEE;
        data_w    <= rd_w ? mb(addr_w) : 8'hEE;
    end

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: consumed bytes form a strictly consecutive pc stream
    // restarting at the redirect target; requests run ahead by at most DEPTH.
    addr_t exp_pc, exp_req, hold_pc;
    inst_t hold_inst;
    bit    hold;
    int    outst;

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            exp_pc  = '0;
            exp_req = '0;
            outst   = 0;
            hold    = 0;
        end else begin
            if (imem_rd)
                chk(imem_addr === exp_req, "req_addr", imem_addr, exp_req);
            if (flush)
                chk(imem_rd === 1'b0, "flush_no_req", imem_rd, 0);
            if (hold)
                chk(byte_valid === 1'b1, "stall_keep_valid", byte_valid, 1);
            if (byte_valid === 1'b1) begin
                chk(pc === exp_pc, "pc_seq", pc, exp_pc);
                chk(inst === mb(pc), "inst_data", inst, mb(pc));
                if (hold) begin
                    chk(pc === hold_pc, "stall_hold_pc", pc, hold_pc);
                    chk(inst === hold_inst, "stall_hold_inst", inst, hold_inst);
                end
            end
            hold      = byte_valid && stall && !flush;
            hold_pc   = pc;
            hold_inst = inst;
            if (flush) begin
                exp_pc  = redirect_pc;
                exp_req = redirect_pc;
                outst   = 0;
            end else begin
                if (imem_rd) begin
                    exp_req = exp_req + 1;
                    outst++;
                end
                if (byte_valid && !stall) begin
                    exp_pc = exp_pc + 1;
                    outst--;
                    ncons++;
                end
                chk(outst <= DEPTH, "credit_bound", outst, DEPTH);
            end
        end
    end

    task automatic cyc(input bit rs, input bit st, input bit fl, input addr_t rp);
        @(posedge clk);
        #1;
        rstn        = rs;
        stall       = st;
        flush       = fl;
        redirect_pc = rp;
        @(negedge clk);
    endtask

    addr_t wexp [4];
    addr_t frz;
    int    k;
    int    n0;

    task automatic flush_seq(input bit st_at_flush, input addr_t tgt);
        cyc(1, st_at_flush, 1, tgt);
        for (int j = 1; j <= 3; j++) begin
            cyc(1, 0, 0, '0);
            if (j == 1) begin
                chk(imem_rd === 1'b1, "flush_req_rd", imem_rd, 1);
                chk(imem_addr === tgt, "flush_req_addr", imem_addr, tgt);
            end
            if (j < 3 - BYP)
                chk(byte_valid === 1'b0, "flush_gap", byte_valid, 0);
            if (j == 3 - BYP) begin
                chk(byte_valid === 1'b1, "flush_first_v", byte_valid, 1);
                chk(pc === tgt, "flush_first_pc", pc, tgt);
                chk(inst === mb(tgt), "flush_first_inst", inst, mb(tgt));
            end
        end
    endtask

    initial begin
        wexp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        wexp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        wexp[2] = 64'h0;
        wexp[3] = 64'h1;
        rstn = 0; stall = 0; flush = 0; redirect_pc = '0;

        repeat (3) cyc(0, 0, 0, '0);
        chk(imem_rd === 1'b0, "rst_rd", imem_rd, 0);
        chk(byte_valid === 1'b0, "rst_valid", byte_valid, 0);
        chk(inst === 8'h00, "rst_inst", inst, 0);
        chk(pc === 64'h0, "rst_pc", pc, 0);
        chk(imem_addr === 64'h0, "rst_addr", imem_addr, 0);
        chk(addr_w === WPC, "rst_addr_w", addr_w, WPC);

        // Free run from reset release; cycle 1 is the first with rstn high.
        for (int c = 1; c <= 8; c++) begin
            cyc(1, 0, 0, '0);
            if (c == 1) begin
                chk(imem_rd === 1'b1, "c1_rd", imem_rd, 1);
                chk(imem_addr === 64'h0, "c1_addr", imem_addr, 0);
            end
            if (c == 2)
                chk(byte_valid === 1'(BYP), "c2_valid", byte_valid, BYP);
            k = c - 3 + BYP;
            if (k >= 0 && k <= 2) begin
                chk(byte_valid === 1'b1, "run_valid", byte_valid, 1);
                chk(pc === 64'(k), "run_pc", pc, k);
                chk(inst === 8'(8'h10 + k), "run_inst", inst, 8'h10 + k);
            end
            if (k >= 0 && k <= 3) begin
                chk(bv_w === 1'b1, "wrap_valid", bv_w, 1);
                chk(pc_w === wexp[k], "wrap_pc", pc_w, wexp[k]);
                chk(inst_w === mb(wexp[k]), "wrap_inst", inst_w, mb(wexp[k]));
            end
        end

        // Ten-cycle stall at steady state.
        frz = (BYP != 0) ? 64'd7 : 64'd6;
        for (int c = 9; c <= 18; c++) begin
            cyc(1, 1, 0, '0);
            chk(pc === frz, "stall_pc", pc, frz);
            if (c >= 12)
                chk(imem_rd === 1'b0, "stall_rd_off", imem_rd, 0);
        end
        for (int c = 19; c <= 24; c++) begin
            cyc(1, 0, 0, '0);
            if (c == 20)
                chk(pc === frz + 1, "release_pc", pc, frz + 1);
        end

        // Flush with bytes buffered after a short stall.
        repeat (3) cyc(1, 1, 0, '0);
        flush_seq(0, 64'h40);
        repeat (6) cyc(1, 0, 0, '0);

        // Flush and stall together while a byte is returning.
        flush_seq(1, 64'h80);
        repeat (4) cyc(1, 0, 0, '0);

        // Random 50% stall.
        n0 = ncons;
        for (int i = 0; i < 1000; i++)
            cyc(1, 1'($urandom_range(0, 1)), 0, '0);
        chk((ncons - n0) >= 300, "rand_progress", ncons - n0, 300);

        // Reset mid-operation behaves like a flush to pc 0.
        cyc(0, 0, 0, '0);
        chk(imem_rd === 1'b0, "mrst_rd", imem_rd, 0);
        chk(byte_valid === 1'b0, "mrst_valid", byte_valid, 0);
        cyc(0, 0, 0, '0);
        chk(pc === 64'h0, "mrst_pc", pc, 0);
        chk(inst === 8'h00, "mrst_inst", inst, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc(1, 0, 0, '0);
            if (c == 1)
                chk(imem_addr === 64'h0, "mrst_addr", imem_addr, 0);
            if (c == 3 - BYP) begin
                chk(pc === 64'h0, "mrst_first_pc", pc, 0);
                chk(inst === 8'h10, "mrst_first_inst", inst, 8'h10);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
